// File: rtl/pulp_dma32_pkg.sv
// Shared types and constants for the PULP cluster 32-bit DMA copy controller.
package pulp_dma32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_DONE
    } state_t;

    localparam logic [2:0] DMA_SIZE_WORD    = 3'b010;
    localparam logic [4:0] DMA_USER_DEFAULT = 5'd0;

    localparam int DBG_STATE_LSB  = 28;
    localparam int DBG_BURSTS_LSB = 16;
    localparam int DBG_WORDS_LSB  = 0;

    function automatic logic [31:0] burst_len(
        input logic [31:0] remaining,
        input logic [31:0] max_burst
    );
        return (remaining < max_burst) ? remaining : max_burst;
    endfunction

endpackage

// File: rtl/pulp_dma32_fifo.sv
// Synchronous staging FIFO: registered storage, combinational head word.
module pulp_dma32_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pulp_cluster_dma32_copy_ctrl.sv
// Word-granular DMA copy controller: read burst -> FIFO -> write burst.
// Optional status counters on debug when PULP_DMA32_COPY_DEBUG_EN is defined.
module pulp_cluster_dma32_copy_ctrl
    import pulp_dma32_pkg::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_reg1,
    input  logic [31:0] conf_info_reg2,
    input  logic [31:0] conf_info_reg3,
    input  logic        conf_done,
    output logic        acc_done,
    output logic [31:0] debug,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    output logic [4:0]  dma_read_ctrl_data_user,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    input  logic [31:0] dma_read_chnl_data,
    output logic        dma_write_ctrl_valid,
    input  logic        dma_write_ctrl_ready,
    output logic [31:0] dma_write_ctrl_data_index,
    output logic [31:0] dma_write_ctrl_data_length,
    output logic [2:0]  dma_write_ctrl_data_size,
    output logic [4:0]  dma_write_ctrl_data_user,
    output logic        dma_write_chnl_valid,
    input  logic        dma_write_chnl_ready,
    output logic [31:0] dma_write_chnl_data
);

    state_t      state;
    state_t      state_nxt;
    logic        conf_q;
    logic        start_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] len_q;
    logic [31:0] offset_q;
    logic [31:0] cnt_q;
    logic [31:0] burst;
    logic [31:0] next_off;
    logic        last_beat;
    logic        start;
    logic        rd_acc;
    logic        wr_acc;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

    assign burst     = burst_len(len_q - offset_q, 32'(MAX_BURST));
    assign next_off  = offset_q + burst;
    assign last_beat = (cnt_q == burst - 32'd1);
    assign start     = (state == ST_IDLE) & start_q;
    assign rd_acc    = dma_read_chnl_valid & dma_read_chnl_ready;
    assign wr_acc    = dma_write_chnl_valid & dma_write_chnl_ready;

    // Edge detect is registered so a level-held conf_done starts one job only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            conf_q  <= conf_done;
            start_q <= conf_done & ~conf_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start_q) begin
                    state_nxt = (conf_info_reg3 == 32'd0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (dma_read_ctrl_ready) state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (rd_acc && last_beat) state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (dma_write_ctrl_ready) state_nxt = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (wr_acc && last_beat) begin
                    state_nxt = (next_off == len_q) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dma_read_ctrl_valid  = 1'b0;
        dma_read_chnl_ready  = 1'b0;
        dma_write_ctrl_valid = 1'b0;
        dma_write_chnl_valid = 1'b0;
        acc_done             = 1'b0;
        unique case (state)
            ST_RD_REQ:  dma_read_ctrl_valid  = 1'b1;
            ST_RD_DATA: dma_read_chnl_ready  = ~fifo_full;
            ST_WR_REQ:  dma_write_ctrl_valid = 1'b1;
            ST_WR_DATA: dma_write_chnl_valid = ~fifo_empty;
            ST_DONE:    acc_done             = 1'b1;
            default: ;
        endcase
    end

    assign dma_read_ctrl_data_index   = src_q + offset_q;
    assign dma_read_ctrl_data_length  = burst;
    assign dma_read_ctrl_data_size    = DMA_SIZE_WORD;
    assign dma_read_ctrl_data_user    = DMA_USER_DEFAULT;
    assign dma_write_ctrl_data_index  = dst_q + offset_q;
    assign dma_write_ctrl_data_length = burst;
    assign dma_write_ctrl_data_size   = DMA_SIZE_WORD;
    assign dma_write_ctrl_data_user   = DMA_USER_DEFAULT;
    assign dma_write_chnl_data        = fifo_head;

    // cnt_q counts beats of the current burst, shared by read and write phases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            offset_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            src_q    <= conf_info_reg1;
            dst_q    <= conf_info_reg2;
            len_q    <= conf_info_reg3;
            offset_q <= '0;
            cnt_q    <= '0;
        end else if (rd_acc || wr_acc) begin
            cnt_q <= last_beat ? 32'd0 : cnt_q + 32'd1;
            if (wr_acc && last_beat) offset_q <= next_off;
        end
    end

    pulp_dma32_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_acc),
        .pop   (wr_acc),
        .wdata (dma_read_chnl_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef PULP_DMA32_COPY_DEBUG_EN
    logic [11:0] bursts_q;
    logic [15:0] words_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bursts_q <= '0;
            words_q  <= '0;
        end else if (start) begin
            bursts_q <= '0;
            words_q  <= '0;
        end else if (wr_acc) begin
            if (words_q != '1) words_q <= words_q + 1'b1;
            if (last_beat && bursts_q != '1) bursts_q <= bursts_q + 1'b1;
        end
    end

    always_comb begin
        debug = '0;
        debug[DBG_STATE_LSB  +: 4]  = {1'b0, state};
        debug[DBG_BURSTS_LSB +: 12] = bursts_q;
        debug[DBG_WORDS_LSB  +: 16] = words_q;
    end
`else
    assign debug = 32'd0;
`endif

endmodule

// File: doc/pulp_cluster_dma32_copy_ctrl.md
# pulp_cluster_dma32_copy_ctrl

Word-granular DMA copy controller for the 32-bit PULP cluster accelerator tile. It sits between the ESP accelerator socket DMA ports and the cluster compute stub. After configuration, it reads a source buffer through the DMA read channels and stages each burst in a local FIFO. It then writes the burst back through the DMA write channels and pulses `acc_done` when the whole buffer is copied.

## Interface
- `MAX_BURST`, 16: maximum words per DMA transaction; power of two, 2..256.
- `FIFO_DEPTH`, 16: staging FIFO depth in words; must be ≥ `MAX_BURST`.
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `conf_info_reg1`  in  32  source word index.
- `conf_info_reg2`  in  32  destination word index.
- `conf_info_reg3`  in  32  copy length in words.
- `conf_done`  in  1  configuration valid; starts a job.
- `acc_done`  out  1  one-cycle job-complete pulse.
- `debug`  out  32  status word; see Configuration.
- `dma_read_ctrl_valid/ready`  out/in  1/1  read request handshake.
- `dma_read_ctrl_data_index`  out  32  read start word index.
- `dma_read_ctrl_data_length`  out  32  read burst length in words.
- `dma_read_ctrl_data_size`  out  3  constant 3'b010 (32-bit word).
- `dma_read_ctrl_data_user`  out  5  constant 0.
- `dma_read_chnl_valid/ready`  in/out  1/1  read data handshake.
- `dma_read_chnl_data`  in  32  read data.
- `dma_write_ctrl_*`: same fields as the read ctrl group, for the write request.
- `dma_write_chnl_valid/ready`  out/in  1/1  write data handshake.
- `dma_write_chnl_data`  out  32  write data.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE.
- Start condition: in IDLE, the controller arms on a rising edge of `conf_done` (registered edge detect).
  - It latches src, dst and len, and clears offset to 0.
  - If len==0, it goes to DONE. Otherwise it goes to RD_REQ.
- Burst size: `burst = min(len - offset, MAX_BURST)`, computed in 32 bits.
- RD_REQ: drive read ctrl valid with index = src + offset and length = burst. On ready, go to RD_DATA.
- RD_DATA: `dma_read_chnl_ready` = FIFO not full. Push each accepted word into the FIFO. Once `burst` words have been accepted, go to WR_REQ.
- WR_REQ: drive write ctrl valid with index = dst + offset and length = burst. On ready, go to WR_DATA.
- WR_DATA: `dma_write_chnl_valid` = FIFO not empty, and data = FIFO head. Pop on valid&ready.
  - After `burst` pops: `offset += burst`.
  - If offset == len, go to DONE. Otherwise go to RD_REQ.
- DONE: assert `acc_done` for exactly one cycle, then return to IDLE.
- `conf_done` edges outside IDLE are ignored.
- Index arithmetic wraps modulo 2^32; no error is flagged.
- Valid/ready handshakes follow AXI-stream rules:
  - Once valid is asserted, it and the data stay stable until ready.
  - Valid never depends combinationally on ready.

## Timing
- Reset values: every valid is 0, `acc_done` is 0, `debug` is 0. Index, length and data outputs are 0. `dma_read_chnl_ready` is 0. State is IDLE, and the FIFO and counters are cleared.
- Latency from the `conf_done` rising edge to `dma_read_ctrl_valid`: 2 cycles (edge-detect register, then RD_REQ).
- Read data is accepted in the same cycle as valid&ready. Full throughput is one word per cycle.
- The first write data word can be presented in the cycle after the write ctrl handshake. Write throughput is one word per cycle.
- len==0: `acc_done` goes high 2 cycles after the `conf_done` edge, with no DMA activity.
- Reset mid-operation forces the reset state immediately. The FIFO is flushed and no `acc_done` is produced.
- A simultaneous FIFO push and pop is legal and leaves the occupancy unchanged. FIFO full/empty are never violated because `FIFO_DEPTH` ≥ `MAX_BURST`.

## Configuration
- Macro: `PULP_DMA32_COPY_DEBUG_EN`.
- Defined: `debug` = {state[3:0], bursts_done[11:0], words_written[15:0]}.
  - The counters clear on job start and saturate at their maximum.
- Undefined: `debug` is tied to 32'd0 and the counters are not instantiated.

## Structure
- Package `pulp_dma32_pkg` holds:
  - the state enum;
  - `DMA_SIZE_WORD` = 3'b010;
  - `DMA_USER_DEFAULT` = 5'd0;
  - the debug field offset constants.
- Sub-module `pulp_dma32_fifo`: synchronous FIFO with parameters DEPTH and WIDTH=32.
  - Outputs full/empty.
  - Registered storage with a combinational head output.

## Test plan
- **Single short burst:** len=5, src=0x100, dst=0x200, all readies held high.
  - One read req (index 0x100, length 5) and one write req (index 0x200, length 5).
  - The 5 words are written in order.
  - `acc_done` pulses once.
- **Chunking:** len=40, `MAX_BURST`=16.
  - Read/write req pairs with lengths 16, 16, 8.
  - Read indices src+0, src+16, src+32; write indices follow the same pattern from dst.
- **Zero length:** len=0.
  - No ctrl valid is ever asserted.
  - `acc_done` goes high exactly 2 cycles after the `conf_done` edge, for 1 cycle.
- **Backpressure:** random read chnl valid gaps and write chnl ready toggling at 50%.
  - Data integrity holds.
  - Valid and data stay stable while ready is low.
  - The FIFO never overflows or underflows.
- **Reset mid-transfer:** assert `rst` low during WR_DATA of burst 2 with len=40.
  - All outputs return to reset values.
  - No `acc_done` is produced.
  - A new `conf_done` edge restarts a full copy from offset 0.
- **Debug build:** with `PULP_DMA32_COPY_DEBUG_EN` defined and len=40, `debug` reads bursts_done=3 and words_written=40 after done.
  - Without the macro, `debug` stays 0 throughout.
